// File: rtl/score_digit_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : score_digit_feeder_if
//  Purpose  : Bundles the score request handshake and the per-pixel glyph
//             lookup signals of score_digit_feeder.
//  Ports    : master - score source / VGA scanner (drives score, score_valid,
//                      pix_x, pix_y; observes busy, overflow, glyph outputs)
//             slave  - the digit feeder itself
//  Revision : 1.0 - initial release
// ============================================================================
interface score_digit_feeder_if #(
    parameter int SCORE_W = 14
);
    logic [SCORE_W-1:0] score;
    logic               score_valid;
    logic               busy;
    logic               overflow;
    logic [9:0]         pix_x;
    logic [9:0]         pix_y;
    logic [3:0]         digit_o;
    logic [3:0]         glyph_x;
    logic [3:0]         glyph_y;
    logic               glyph_en;

    modport master (
        output score, score_valid, pix_x, pix_y,
        input  busy, overflow, digit_o, glyph_x, glyph_y, glyph_en
    );

    modport slave (
        input  score, score_valid, pix_x, pix_y,
        output busy, overflow, digit_o, glyph_x, glyph_y, glyph_en
    );
endinterface
`default_nettype wire

// File: rtl/score_digit_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : score_digit_feeder
//  Purpose  : Converts a binary score to decimal with a bit-serial
//             double-dabble engine and, per pixel, supplies the digit code and
//             in-cell coordinates to the glyph renderer.
//  Ports    : sys_clk   - pixel clock, rising edge
//             sys_rst_n - asynchronous active-low reset
//             bus       - score_digit_feeder_if.slave (score request,
//                         busy/overflow status, pixel coords, glyph outputs)
//  Revision : 1.0 - initial release
// ============================================================================
module score_digit_feeder #(
    parameter int         SCORE_W  = 14,
    parameter int         DIGITS   = 4,
    parameter logic [9:0] ORIGIN_X = 10'd16,
    parameter logic [9:0] ORIGIN_Y = 10'd16,
    parameter int         GLYPH_W  = 8,
    parameter int         GLYPH_H  = 8,
    parameter bit         LZ_BLANK = 1'b1
) (
    input wire             sys_clk,
    input wire             sys_rst_n,
    score_digit_feeder_if.slave bus
);

    function automatic logic [31:0] f_pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

    localparam logic [31:0] c_MAX   = f_pow10(DIGITS) - 32'd1;
    localparam int          c_BW    = 4 * DIGITS;
    localparam int          c_CW    = $clog2(SCORE_W + 1);
    localparam int          c_GXB   = $clog2(GLYPH_W);
    localparam logic [10:0] c_X_END = {1'b0, ORIGIN_X} + 11'(DIGITS * GLYPH_W);
    localparam logic [10:0] c_Y_END = {1'b0, ORIGIN_Y} + 11'(GLYPH_H);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    function automatic logic f_over(input logic [SCORE_W-1:0] s);
        return 32'(s) > c_MAX;
    endfunction

    function automatic logic [SCORE_W-1:0] f_sat(input logic [SCORE_W-1:0] s);
        return f_over(s) ? SCORE_W'(c_MAX) : s;
    endfunction

    state_t             r_state, w_state_nxt;
    logic [SCORE_W-1:0] r_bin, w_bin_nxt;
    logic [c_BW-1:0]    r_bcd, w_bcd_nxt;
    logic [c_CW-1:0]    r_cnt, w_cnt_nxt;
    logic               r_sat, w_sat_nxt;
    logic               r_pend_v, w_pend_v_nxt;
    logic [SCORE_W-1:0] r_pend_s, w_pend_s_nxt;
    logic [c_BW-1:0]    r_bank, w_bank_nxt;     // MSD in the top nibble
    logic               r_ovf, w_ovf_nxt;
    logic               w_start;
    logic [SCORE_W-1:0] w_start_score;
    logic [c_BW-1:0]    w_adj;

    // Add-3 correction on every nibble before the shift.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign w_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? r_bcd[4*d +: 4] + 4'd3
                                                            : r_bcd[4*d +: 4];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= S_IDLE;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_sat    <= 1'b0;
            r_pend_v <= 1'b0;
            r_pend_s <= '0;
            r_bank   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bin    <= w_bin_nxt;
            r_bcd    <= w_bcd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sat    <= w_sat_nxt;
            r_pend_v <= w_pend_v_nxt;
            r_pend_s <= w_pend_s_nxt;
            r_bank   <= w_bank_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bin_nxt     = r_bin;
        w_bcd_nxt     = r_bcd;
        w_cnt_nxt     = r_cnt;
        w_sat_nxt     = r_sat;
        w_pend_v_nxt  = r_pend_v;
        w_pend_s_nxt  = r_pend_s;
        w_bank_nxt    = r_bank;
        w_ovf_nxt     = r_ovf;
        w_start       = 1'b0;
        w_start_score = bus.score;
        case (r_state)
            S_IDLE: begin
                if (bus.score_valid) w_start = 1'b1;
            end
            S_SHIFT: begin
                {w_bcd_nxt, w_bin_nxt} = {w_adj[c_BW-2:0], r_bin, 1'b0};
                w_cnt_nxt = r_cnt - c_CW'(1);
                if (r_cnt == c_CW'(1)) w_state_nxt = S_COMMIT;
                // Requests during a conversion park here; newest overwrites.
                if (bus.score_valid) begin
                    w_pend_v_nxt = 1'b1;
                    w_pend_s_nxt = bus.score;
                end
            end
            S_COMMIT: begin
                w_bank_nxt = r_bcd;
                w_ovf_nxt  = r_sat;
                // A request arriving now is newer than any parked one.
                if (bus.score_valid) begin
                    w_start = 1'b1;
                end else if (r_pend_v) begin
                    w_start       = 1'b1;
                    w_start_score = r_pend_s;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_start) begin
            w_bin_nxt    = f_sat(w_start_score);
            w_sat_nxt    = f_over(w_start_score);
            w_bcd_nxt    = '0;
            w_cnt_nxt    = c_CW'(SCORE_W);
            w_pend_v_nxt = 1'b0;
            w_state_nxt  = S_SHIFT;
        end
    end

    // ---------------------------------------------------------------- pixels
    logic       w_in_field;
    logic [9:0] w_dx, w_dy, w_idx;
    logic [3:0] w_gx, w_gy, w_digit;
    logic       w_blk;
    logic [DIGITS-1:0] w_blank;              // bit 0 = most significant cell

    for (genvar d = 0; d < DIGITS; d++) begin : g_blank
        if (d == DIGITS - 1 || !LZ_BLANK) begin : g_keep
            assign w_blank[d] = 1'b0;
        end else if (d == 0) begin : g_msd
            assign w_blank[d] = (r_bank[4*(DIGITS-1-d) +: 4] == 4'd0);
        end else begin : g_mid
            assign w_blank[d] = (r_bank[4*(DIGITS-1-d) +: 4] == 4'd0) && w_blank[d-1];
        end
    end

    // Widened upper-bound compares so a field near column 1023 cannot wrap.
    assign w_in_field = (bus.pix_x >= ORIGIN_X) && ({1'b0, bus.pix_x} < c_X_END) &&
                        (bus.pix_y >= ORIGIN_Y) && ({1'b0, bus.pix_y} < c_Y_END);
    assign w_dx  = bus.pix_x - ORIGIN_X;
    assign w_dy  = bus.pix_y - ORIGIN_Y;
    assign w_idx = w_dx >> c_GXB;
    assign w_gx  = 4'(w_dx & 10'(GLYPH_W - 1));
    assign w_gy  = 4'(w_dy & 10'(GLYPH_H - 1));

    always_comb begin
        w_digit = 4'd0;
        w_blk   = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_idx == 10'(d)) begin
                w_digit = r_bank[4*(DIGITS-1-d) +: 4];
                w_blk   = w_blank[d];
            end
        end
    end

    logic [3:0] r_digit, r_gx, r_gy;
    logic       r_en;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_digit <= 4'd0;
            r_gx    <= 4'd0;
            r_gy    <= 4'd0;
            r_en    <= 1'b0;
        end else if (w_in_field) begin
            r_digit <= w_digit;
            r_gx    <= w_gx;
            r_gy    <= w_gy;
            r_en    <= !w_blk;
        end else begin
            r_digit <= 4'd0;
            r_gx    <= 4'd0;
            r_gy    <= 4'd0;
            r_en    <= 1'b0;
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.overflow = r_ovf;
    assign bus.digit_o  = r_digit;
    assign bus.glyph_x  = r_gx;
    assign bus.glyph_y  = r_gy;
    assign bus.glyph_en = r_en;

endmodule
`default_nettype wire

// File: tb/tb_score_digit_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_digit_feeder
//  Purpose  : Self-checking bench for score_digit_feeder. Expected displays
//             are queued when a score is driven and popped when the bank is
//             read back through the pixel path.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_digit_feeder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    score_digit_feeder_if #(.SCORE_W(14)) bus ();

    score_digit_feeder #(
        .SCORE_W(14), .DIGITS(4), .ORIGIN_X(10'd16), .ORIGIN_Y(10'd16),
        .GLYPH_W(8), .GLYPH_H(8), .LZ_BLANK(1'b1)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t model(input int s);
        exp_t e;
        int   v;
        e.ovf = (s > 9999);
        v     = e.ovf ? 9999 : s;
        e.bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
        return e;
    endfunction

    function automatic logic [3:0] exp_digit(input exp_t e, input int i);
        logic [15:0] b;
        b = e.bcd;
        return b[15-4*i -: 4];
    endfunction

    function automatic logic exp_en(input exp_t e, input int i);
        logic lead;
        lead = 1'b1;
        for (int k = 0; k <= i; k++)
            if (exp_digit(e, k) != 4'd0) lead = 1'b0;
        return !(lead && i < 3);
    endfunction

    task automatic drive_pix(input int x, input int y);
        bus.pix_x = 10'(x);
        bus.pix_y = 10'(y);
    endtask

    task automatic pulse(input int s);
        bus.score       = 14'(s);
        bus.score_valid = 1'b1;
        @(negedge clk);
        bus.score_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_timeout: busy=%b want 0", tag, bus.busy);
        end
    endtask

    task automatic check_display(input string tag);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty", tag);
            return;
        end
        e = exp_q.pop_front();
        if (bus.overflow !== e.ovf) begin
            errors++;
            $display("FAIL %s overflow: got %b want %b", tag, bus.overflow, e.ovf);
        end
        for (int i = 0; i < 4; i++) begin
            drive_pix(16 + 8 * i + 3, 21);
            @(negedge clk);
            checks++;
            if (bus.digit_o !== exp_digit(e, i)) begin
                errors++;
                $display("FAIL %s digit[%0d]: got %0d want %0d", tag, i, bus.digit_o, exp_digit(e, i));
            end
            checks++;
            if (bus.glyph_en !== exp_en(e, i)) begin
                errors++;
                $display("FAIL %s glyph_en[%0d]: got %b want %b", tag, i, bus.glyph_en, exp_en(e, i));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({bus.busy, bus.overflow, bus.digit_o, bus.glyph_x, bus.glyph_y, bus.glyph_en} !== 15'd0) begin
            errors++;
            $display("FAIL %s outputs_zero: busy=%b ovf=%b digit=%0d gx=%0d gy=%0d en=%b want all 0",
                     tag, bus.busy, bus.overflow, bus.digit_o, bus.glyph_x, bus.glyph_y, bus.glyph_en);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_pix(47, 23);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(model(0));
        check_display("reset_display");
    endtask

    task automatic test_convert();
        int n;
        exp_q.push_back(model(1234));
        pulse(1234);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL convert busy_cycles: got %0d want 15", n);
        end
        check_display("convert_1234");
    endtask

    task automatic test_blanking();
        exp_q.push_back(model(0));
        pulse(0);
        wait_idle("blank_0");
        check_display("blank_0");
        exp_q.push_back(model(7));
        pulse(7);
        wait_idle("blank_7");
        check_display("blank_7");
    endtask

    task automatic test_saturate();
        exp_q.push_back(model(12000));
        pulse(12000);
        wait_idle("sat_12000");
        check_display("sat_12000");
        exp_q.push_back(model(42));
        pulse(42);
        wait_idle("sat_42");
        check_display("sat_42");
    endtask

    task automatic test_back_to_back();
        exp_t e1;
        logic exp_busy;
        e1 = '0;
        for (int c = 0; c <= 33; c++) begin
            if (c >= 1) begin
                exp_busy = (c <= 30);
                checks++;
                if (bus.busy !== exp_busy) begin
                    errors++;
                    $display("FAIL b2b busy@%0d: got %b want %b", c, bus.busy, exp_busy);
                end
            end
            if (c == 16 && exp_q.size() != 0) e1 = exp_q.pop_front();
            if (c >= 17 && c <= 20) begin
                checks++;
                if (bus.digit_o !== exp_digit(e1, c - 17) || bus.glyph_en !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b first_digit[%0d]: got %0d/en=%b want %0d/en=1",
                             c - 17, bus.digit_o, bus.glyph_en, exp_digit(e1, c - 17));
                end
            end
            bus.score_valid = (c == 0 || c == 3 || c == 5);
            bus.score = (c == 0) ? 14'd1234 : (c == 3) ? 14'd5678 : 14'd9012;
            if (c == 0) exp_q.push_back(model(1234));
            if (c == 3) exp_q.push_back(model(5678));
            if (c == 5) begin
                void'(exp_q.pop_back());      // newer request replaces parked one
                exp_q.push_back(model(9012));
            end
            if (c >= 16 && c <= 19) drive_pix(16 + 8 * (c - 16), 16);
            @(negedge clk);
        end
        bus.score_valid = 1'b0;
        check_display("b2b_second");
    endtask

    task automatic test_pixel();
        // Display holds 9012 here.
        int         px [5] = '{16, 31, 48, 15, 16};
        int         py [5] = '{16, 23, 16, 16, 24};
        logic [3:0] ed [5] = '{4'd9, 4'd0, 4'd0, 4'd0, 4'd0};
        logic [3:0] egx[5] = '{4'd0, 4'd7, 4'd0, 4'd0, 4'd0};
        logic [3:0] egy[5] = '{4'd0, 4'd7, 4'd0, 4'd0, 4'd0};
        logic       een[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive_pix(px[i], py[i]);
            @(negedge clk);
            checks++;
            if (bus.digit_o !== ed[i] || bus.glyph_x !== egx[i] ||
                bus.glyph_y !== egy[i] || bus.glyph_en !== een[i]) begin
                errors++;
                $display("FAIL pixel(%0d,%0d): got d=%0d gx=%0d gy=%0d en=%b want d=%0d gx=%0d gy=%0d en=%b",
                         px[i], py[i], bus.digit_o, bus.glyph_x, bus.glyph_y, bus.glyph_en,
                         ed[i], egx[i], egy[i], een[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_pix(47, 23);                    // last cell of 9012: digit 2, gx=gy=7
        pulse(5555);
        repeat (6) @(negedge clk);            // now in cycle 7 of the conversion
        checks++;
        if (bus.busy !== 1'b1 || bus.digit_o !== 4'd2 || bus.glyph_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pre: busy=%b d=%0d en=%b want 1/2/1", bus.busy, bus.digit_o, bus.glyph_en);
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid busy_after: got %b want 0", bus.busy);
        end
        exp_q.push_back(model(0));
        check_display("rst_mid_display");
    endtask

    initial begin
        bus.score       = '0;
        bus.score_valid = 1'b0;
        bus.pix_x       = '0;
        bus.pix_y       = '0;
        @(negedge clk);
        test_reset();
        test_convert();
        test_blanking();
        test_saturate();
        test_back_to_back();
        test_pixel();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
